// File: rtl/mmio_io_controller_pkg.sv
// mmio_pkg: shared register offsets, SR/CR bit indices and output FSM state type
package mmio_pkg;
  localparam logic [3:0] OFF_DIR = 4'h0;
  localparam logic [3:0] OFF_DOR = 4'h4;
  localparam logic [3:0] OFF_SR  = 4'h8;
  localparam logic [3:0] OFF_CR  = 4'hC;
  localparam int SR_DIR_FULL = 0;
  localparam int SR_OUT_IDLE = 1;
  localparam int SR_OVERRUN  = 2;
  localparam int CR_IN_EN    = 0;
  localparam int CR_OUT_EN   = 1;
  localparam int CR_IN_IE    = 2;
  localparam int CR_OUT_IE   = 3;
  typedef enum logic {O_IDLE, O_SEND} out_state_e;
endpackage

// File: rtl/mmio_io_controller_out_fsm.sv
// mmio_out_fsm: DOR register, output handshake FSM and sticky overrun flag
module mmio_out_fsm
  import mmio_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_dor,
  input  logic [DATA_W-1:0] wdata,
  input  logic              out_en,
  input  logic              rd_sr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_idle,
  output logic              overrun
);
  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] dor_q, dor_d;
  logic              overrun_q, overrun_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= O_IDLE;
      dor_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dor_q     <= dor_d;
      overrun_q <= overrun_d;
    end
  end
  // a store while sending is dropped and flagged; the flag set beats an SR read clear
  always_comb begin
    state_d   = (state_q == O_IDLE) ? ((wr_dor && out_en) ? O_SEND : O_IDLE)
                                    : (out_ready ? O_IDLE : O_SEND);
    dor_d     = (wr_dor && state_q == O_IDLE) ? wdata : dor_q;
    overrun_d = (wr_dor && state_q == O_SEND) | (overrun_q & ~rd_sr);
  end
  always_comb begin
    out_valid = (state_q == O_SEND);
    out_idle  = (state_q == O_IDLE);
    out_data  = dor_q;
    overrun   = overrun_q;
  end
endmodule

// File: rtl/mmio_io_controller.sv
// mmio_io_controller: CPU-mapped DIR/DOR/SR/CR window driving one input and one output device
// Define MMIO_IO_IRQ_EN to build the registered interrupt output and out_done tracking.
module mmio_io_controller
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic              sel,
  output logic [31:0]       rdata,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              irq
);
  logic [DATA_W-1:0] dir_q, dir_d;
  logic              dir_full_q, dir_full_d;
  logic [3:0]        cr_q, cr_d;
  logic [3:0]        off;
  logic [31:0]       sr;
  logic              rd_dir, rd_sr, wr_dor, wr_cr, take, out_idle, overrun;
  logic              unused_addr;
  assign unused_addr = ^addr[1:0];
  always_comb begin
    sel      = (addr[31:4] == BASE_ADDR[31:4]);
    off      = {addr[3:2], 2'b00};
    rd_dir   = sel && re && off == OFF_DIR;
    rd_sr    = sel && re && off == OFF_SR;
    wr_dor   = sel && we && off == OFF_DOR;
    wr_cr    = sel && we && off == OFF_CR;
    in_ready = cr_q[CR_IN_EN] & ~dir_full_q;
    take     = in_valid & in_ready;
    sr       = {29'b0, overrun, out_idle, dir_full_q};
    rdata    = !sel             ? 32'b0 :
               off == OFF_DIR   ? 32'(dir_q) :
               off == OFF_DOR   ? 32'(out_data) :
               off == OFF_SR    ? sr : {28'b0, cr_q};
    // a DIR read clears full even if new data waits; in_ready was already low
    dir_full_d = rd_dir ? 1'b0 : (take | dir_full_q);
    dir_d      = take ? in_data : dir_q;
    cr_d       = wr_cr ? wdata[3:0] : cr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= '0;
      dir_full_q <= 1'b0;
      cr_q       <= '0;
    end else begin
      dir_q      <= dir_d;
      dir_full_q <= dir_full_d;
      cr_q       <= cr_d;
    end
  end
  mmio_out_fsm #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .wr_dor    (wr_dor),
    .wdata     (wdata[DATA_W-1:0]),
    .out_en    (cr_q[CR_OUT_EN]),
    .rd_sr     (rd_sr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idle  (out_idle),
    .overrun   (overrun)
  );
`ifdef MMIO_IO_IRQ_EN
  logic out_done_q, out_done_d, irq_q, irq_d;
  always_comb begin
    out_done_d = (out_valid && out_ready) ? 1'b1 : (rd_sr || wr_dor) ? 1'b0 : out_done_q;
    irq_d      = (cr_q[CR_IN_IE] & dir_full_q) | (cr_q[CR_OUT_IE] & out_idle & out_done_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_done_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_done_q <= out_done_d;
      irq_q      <= irq_d;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule
